// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package reg_file_mp_pkg;

   // Sweep/operate controller states
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Number of entries addressed by an aw-bit address
   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage : reg_file_mp_pkg

// File: rtl/reg_file_mp_bank.sv
// One 1R1W storage bank: unreset array, registered read with enable.
module reg_file_mp_bank
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wa,
   input  logic [DATA_W-1:0] i_wd,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_ra,
   output logic [DATA_W-1:0] o_rd
);

   localparam int unsigned DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Array write; no reset so the array stays RAM-mappable
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wa] <= i_wd;
   end

   // Registered read; sees the pre-write contents on an address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       o_rd <= '0;
      else if (i_rd_en) o_rd <= r_mem[i_ra];
   end

endmodule : reg_file_mp_bank

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, write bypass and post-reset clear sweep.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 5,
   parameter int unsigned NUM_READ       = 2,
   parameter int unsigned ZERO_REG       = 1,
   parameter int unsigned BYPASS         = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_READ*ADDR_W-1:0]   ra,
   input  logic [NUM_READ-1:0]          re,
   input  logic [ADDR_W-1:0]            wa,
   input  logic [DATA_W-1:0]            din,
   input  logic                         we,
   output logic [NUM_READ*DATA_W-1:0]   dout,
   output logic                         ready
);

   localparam int unsigned DEPTH = depth_of(ADDR_W);
   localparam int unsigned CW    = ADDR_W + 1;

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_clr_idx, w_clr_idx_nxt;
   logic                r_ready, w_ready_nxt;

   logic                w_clearing;
   logic                w_running;
   logic                w_wr_ext;
   logic                w_bank_we;
   logic [ADDR_W-1:0]   w_bank_wa;
   logic [DATA_W-1:0]   w_bank_wd;

   assign w_clearing = (r_state == ST_CLEAR);
   assign w_running  = (r_state == ST_RUN);
   assign w_wr_ext   = w_running && we && !((ZERO_REG != 0) && (wa == '0));

   // Bank write port shared by the sweep and the external writer
   assign w_bank_we = w_clearing || w_wr_ext;
   assign w_bank_wa = w_clearing ? r_clr_idx[ADDR_W-1:0] : wa;
   assign w_bank_wd = w_clearing ? '0 : din;

   assign ready = r_ready;

   // Controller state, sweep index and ready flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         r_clr_idx <= '0;
         r_ready   <= (CLEAR_ON_RESET == 0);
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clr_idx_nxt;
         r_ready   <= w_ready_nxt;
      end
   end

   // Sweep advances one entry per edge; last entry hands over to RUN
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      w_ready_nxt   = r_ready;
      case (r_state)
         ST_CLEAR: begin
            w_clr_idx_nxt = r_clr_idx + CW'(1);
            if (r_clr_idx == CW'(DEPTH - 1)) begin
               w_state_nxt = ST_RUN;
               w_ready_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_port
      logic [ADDR_W-1:0] w_ra;
      logic              w_rd_en;
      logic              w_zero_hit;
      logic              w_byp_hit;
      logic [DATA_W-1:0] w_bank_rd;
      logic              r_ovr;
      logic [DATA_W-1:0] r_ovr_data;

      assign w_ra       = ra[p*ADDR_W +: ADDR_W];
      assign w_rd_en    = w_running && re[p];
      assign w_zero_hit = (ZERO_REG != 0) && (w_ra == '0);
      assign w_byp_hit  = (BYPASS != 0) && w_wr_ext && (wa == w_ra);

      reg_file_mp_bank #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_we    (w_bank_we),
         .i_wa    (w_bank_wa),
         .i_wd    (w_bank_wd),
         .i_rd_en (w_rd_en),
         .i_ra    (w_ra),
         .o_rd    (w_bank_rd)
      );

      // Registered override: zero register or forwarded write data wins over the bank
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ovr      <= 1'b1;
            r_ovr_data <= '0;
         end else if (w_rd_en) begin
            r_ovr      <= w_zero_hit || w_byp_hit;
            r_ovr_data <= w_zero_hit ? '0 : din;
         end
      end

      assign dout[p*DATA_W +: DATA_W] = r_ovr ? r_ovr_data : w_bank_rd;
   end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_READ = 2;
   localparam int unsigned DEPTH    = 32;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [NUM_READ*ADDR_W-1:0]  ra;
   logic [NUM_READ-1:0]         re;
   logic [ADDR_W-1:0]           wa;
   logic [DATA_W-1:0]           din;
   logic                        we;
   logic [NUM_READ*DATA_W-1:0]  dout;
   logic                        ready;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W-1:0] m_mem  [DEPTH];
   logic [DATA_W-1:0] m_dout [NUM_READ];
   int                m_edges;

   always #5 clk = ~clk;

   reg_file_mp #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ),
      .ZERO_REG(1), .BYPASS(1), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ra(ra), .re(re), .wa(wa),
      .din(din), .we(we), .dout(dout), .ready(ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".ready"}, 32'(ready), 32'(m_edges >= int'(DEPTH)));
      for (int p = 0; p < int'(NUM_READ); p++)
         check($sformatf("%s.dout%0d", tag, p), dout[p*DATA_W +: DATA_W], m_dout[p]);
   endtask

   task automatic set_ra(input int p, input logic [ADDR_W-1:0] a);
      ra[p*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic idle_inputs();
      we = 1'b0; re = '0; wa = '0; din = '0; ra = '0;
   endtask

   // Apply one clock edge to the model, then compare the DUT after the edge
   task automatic tick(input string tag);
      logic [ADDR_W-1:0] a;
      if (m_edges >= int'(DEPTH)) begin
         for (int p = 0; p < int'(NUM_READ); p++) begin
            if (re[p]) begin
               a = ra[p*ADDR_W +: ADDR_W];
               if (a == 0)                 m_dout[p] = '0;
               else if (we && wa == a)     m_dout[p] = din;
               else                        m_dout[p] = m_mem[a];
            end
         end
         if (we && wa != 0) m_mem[wa] = din;
      end else begin
         m_edges++;
         if (m_edges == int'(DEPTH))
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      m_edges = 0;
      for (int p = 0; p < int'(NUM_READ); p++) m_dout[p] = '0;
   endtask

   // Asynchronous reset pulse taken mid-cycle, released on a falling edge
   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs(tag);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Sweep with external traffic that must be ignored
      for (int i = 0; i < int'(DEPTH); i++) begin
         we = 1'b1; wa = 5'd3; din = 32'hDEAD; re = 2'b11;
         set_ra(0, 5'd3); set_ra(1, 5'd3);
         tick("sweep");
      end
      idle_inputs();

      // Every entry reads zero on both ports
      for (int i = 0; i < int'(DEPTH); i++) begin
         re = 2'b11; set_ra(0, ADDR_W'(i)); set_ra(1, ADDR_W'(DEPTH - 1 - i));
         tick("read_all");
      end

      // Write then read back on both ports
      re = '0; we = 1'b1; wa = 5'd5; din = 32'h1234_5678;
      tick("wr5");
      we = 1'b0; re = 2'b11; set_ra(0, 5'd5); set_ra(1, 5'd5);
      tick("rd5");

      // Same-cycle write/read bypass, other port on the zero register
      we = 1'b1; wa = 5'd7; din = 32'hA5A5_A5A5; re = 2'b11;
      set_ra(0, 5'd7); set_ra(1, 5'd0);
      tick("bypass7");

      // Writes to entry 0 are dropped
      we = 1'b1; wa = 5'd0; din = 32'hFFFF_FFFF; re = 2'b00;
      tick("wr0");
      we = 1'b0; re = 2'b11; set_ra(0, 5'd0); set_ra(1, 5'd0);
      tick("rd0");

      // Read disabled: outputs hold while the entry is rewritten
      re = 2'b11; set_ra(0, 5'd7); set_ra(1, 5'd5); we = 1'b0;
      tick("rd_hold_pre");
      re = 2'b00; we = 1'b1; wa = 5'd7; din = 32'h0BAD_F00D;
      tick("hold_a");
      we = 1'b1; wa = 5'd5; din = 32'h5555_AAAA;
      tick("hold_b");
      we = 1'b0; re = 2'b11;
      tick("hold_after");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         we  = 1'($urandom);
         wa  = ADDR_W'($urandom);
         din = $urandom;
         re  = NUM_READ'($urandom);
         for (int p = 0; p < int'(NUM_READ); p++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)       set_ra(p, wa);
            else if (sel < 6)  set_ra(p, '0);
            else               set_ra(p, ADDR_W'($urandom));
         end
         tick("rand");
      end
      idle_inputs();

      // Reset mid-operation: outputs drop immediately, sweep restarts
      pulse_reset("rst_run");
      for (int i = 0; i < 17; i++) tick("sweep2");

      // Reset mid-sweep at entry 17, then a full sweep again
      pulse_reset("rst_sweep");
      for (int i = 0; i < int'(DEPTH) + 2; i++) tick("sweep3");

      // After the restarted sweep, previously written data is gone
      re = 2'b11; set_ra(0, 5'd5); set_ra(1, 5'd7);
      tick("rd_after_reset");
      for (int i = 0; i < 100; i++) begin
         we  = 1'($urandom);
         wa  = ADDR_W'($urandom_range(0, 3));
         din = $urandom;
         re  = NUM_READ'($urandom);
         set_ra(0, ADDR_W'($urandom_range(0, 3)));
         set_ra(1, ADDR_W'($urandom_range(0, 3)));
         tick("rand_narrow");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_file_mp
